// File: rtl/alu_logical_pkg.sv
// Shared definitions for the alu_logical arbiter: opcode encodings, FSM state
// encoding, the ALU control bundle and the opcode decoder.
package alu_logical_pkg;

  localparam int OPW_C = 3;

  localparam logic [OPW_C-1:0] OP_AND  = 3'b000;
  localparam logic [OPW_C-1:0] OP_OR   = 3'b001;
  localparam logic [OPW_C-1:0] OP_NAND = 3'b010;
  localparam logic [OPW_C-1:0] OP_NOR  = 3'b011;
  localparam logic [OPW_C-1:0] OP_ZERO = 3'b100;
  localparam logic [OPW_C-1:0] OP_ONES = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Bit order matches the ALU control pins {andl, orl, zero, inv}.
  typedef struct packed {
    logic andl;
    logic orl;
    logic zero;
    logic inv;
  } ctrl_t;

  // Reserved opcodes (11x) have no ALU meaning.
  function automatic logic op_reserved(input logic [OPW_C-1:0] op);
    return op[2] & op[1];
  endfunction

  // Reserved opcodes decode to all controls low.
  function automatic ctrl_t op_decode(input logic [OPW_C-1:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_AND:  c.andl = 1'b1;
      OP_OR:   c.orl  = 1'b1;
      OP_NAND: begin c.andl = 1'b1; c.inv = 1'b1; end
      OP_NOR:  begin c.orl  = 1'b1; c.inv = 1'b1; end
      OP_ZERO: c.zero = 1'b1;
      OP_ONES: begin c.zero = 1'b1; c.inv = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, async active-high reset
//   req[1:0] : request lines
//   take     : arbitration enabled this cycle (grant may be issued)
//   gnt[1:0] : one-hot grant, only while take is high
//   id       : index of the requester that would win
// last_grant resets to 1 so requester 0 wins the first contested round.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt,
  output logic       id
);

  logic last_grant;

  always_comb begin
    id = 1'b0;
    if (req == 2'b11) id = ~last_grant;
    else if (req[1])  id = 1'b1;
  end

  // Masking with req keeps gnt at 0 when nobody asks.
  assign gnt = take ? ((id ? 2'b10 : 2'b01) & req) : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last_grant <= 1'b1;
    else if (|gnt)  last_grant <= id;
  end

endmodule

// File: rtl/alu_logical_arbiter.sv
// Shares one combinational alu_logical unit between two requesters.
//   r0_*/r1_*  : command channels (valid/ready handshake, op, a, b)
//   rsp_*      : registered response (valid/ready, data, owner id, reserved-op flag)
//   alu_*      : operands and control selects to the ALU; alu_f is its result
//   busy       : high whenever the FSM is not idle
// A command is accepted in IDLE, drives the ALU for one EXEC cycle, and the
// result is held in RESP until the consumer takes it.
module alu_logical_arbiter
  import alu_logical_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = OPW_C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [OPW-1:0]   r0_op,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [OPW-1:0]   r1_op,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_andl,
  output logic             alu_orl,
  output logic             alu_zero,
  output logic             alu_inv,
  input  logic [WIDTH-1:0] alu_f,
  output logic             busy
);

  state_t           state;
  ctrl_t            ctrl;
  logic             id_q;
  logic             err_q;
  logic [1:0]       gnt;
  logic             win_id;
  logic             take;
  logic [OPW-1:0]   win_op;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;

  // Readys are combinational; gating with rst keeps them low during reset.
  assign take = (state == S_IDLE) && !rst;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  ({r1_valid, r0_valid}),
    .take (take),
    .gnt  (gnt),
    .id   (win_id)
  );

  assign r0_ready = gnt[0];
  assign r1_ready = gnt[1];

  assign win_op = win_id ? r1_op : r0_op;
  assign win_a  = win_id ? r1_a  : r0_a;
  assign win_b  = win_id ? r1_b  : r0_b;

  assign {alu_andl, alu_orl, alu_zero, alu_inv} = ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ctrl      <= '0;
      id_q      <= 1'b0;
      err_q     <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|gnt) begin
            // alu_a/alu_b double as the operand latch.
            alu_a <= win_a;
            alu_b <= win_b;
            ctrl  <= op_decode(win_op);
            err_q <= op_reserved(win_op);
            id_q  <= win_id;
            busy  <= 1'b1;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_data  <= err_q ? '0 : alu_f;
          rsp_id    <= id_q;
          rsp_err   <= err_q;
          rsp_valid <= 1'b1;
          ctrl      <= '0;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_logical_arbiter.sv
// Bench for alu_logical_arbiter with a behavioural alu_logical model.
// Expected responses are queued at command acceptance and popped by a
// monitor whenever a response handshake completes.
module tb_alu_logical_arbiter;
  localparam int WIDTH = 8;
  localparam int OPW   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             r0_valid, r0_ready, r1_valid, r1_ready;
  logic [OPW-1:0]   r0_op, r1_op;
  logic [WIDTH-1:0] r0_a, r0_b, r1_a, r1_b;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [WIDTH-1:0] rsp_data, alu_a, alu_b, alu_f, alu_base;
  logic             alu_andl, alu_orl, alu_zero, alu_inv, busy;

  alu_logical_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_andl(alu_andl), .alu_orl(alu_orl),
    .alu_zero(alu_zero), .alu_inv(alu_inv), .alu_f(alu_f), .busy(busy)
  );

  // alu_logical model: select base function, optionally invert.
  assign alu_base = alu_andl ? (alu_a & alu_b) : alu_orl ? (alu_a | alu_b) : '0;
  assign alu_f    = alu_inv ? ~alu_base : alu_base;

  always #5 clk = ~clk;

  typedef struct packed {
    logic       id;
    logic       err;
    logic [7:0] data;
  } rsp_t;

  rsp_t sb[$];
  int   glog[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  rsp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every completed response against the scoreboard.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got id=%0d err=%0d data=%0h expected none",
                 rsp_id, rsp_err, rsp_data);
      end else begin
        mon_e = sb.pop_front();
        check("rsp {id,err,data}", {22'd0, rsp_id, rsp_err, rsp_data}, {22'd0, mon_e});
      end
    end
  end

  // Present a command on requester r, wait (bounded) for ready, queue expectation.
  // Returns at posedge+1 of the accepting edge, i.e. during EXEC.
  task automatic do_req(input int r, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_d,
                        input logic exp_err, input bit push);
    bit got;
    got = 1'b0;
    @(negedge clk);
    if (r == 0) begin r0_valid = 1'b1; r0_op = op; r0_a = a; r0_b = b; end
    else        begin r1_valid = 1'b1; r1_op = op; r1_a = a; r1_b = b; end
    for (int i = 0; i < 100 && !got; i++) begin
      #1;
      if ((r == 0) ? r0_ready : r1_ready) begin
        got = 1'b1;
        if (push) sb.push_back({r[0], exp_err, exp_d});
        glog.push_back(r);
        @(posedge clk);
        #1;
        if (r == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout r%0d: got no ready expected ready", r);
      if (r == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
    end
  endtask

  function automatic logic [3:0] ctrl_v();
    return {alu_andl, alu_orl, alu_zero, alu_inv};
  endfunction

  logic [7:0] r0_d [4] = '{8'h80, 8'hFD, 8'h7F, 8'h02};
  logic [2:0] r0_o [4] = '{3'b000, 3'b001, 3'b010, 3'b011};
  logic [7:0] r1_d [4] = '{8'h00, 8'hFF, 8'h0C, 8'h3F};
  logic [2:0] r1_o [4] = '{3'b100, 3'b101, 3'b000, 3'b001};
  logic [7:0] r1_xa[4] = '{8'h00, 8'h00, 8'h3C, 8'h3C};
  logic [7:0] r1_xb[4] = '{8'hFF, 8'hFF, 8'h0F, 8'h0F};

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    r0_valid = 0; r0_op = '0; r0_a = '0; r0_b = '0;
    r1_valid = 0; r1_op = '0; r1_a = '0; r1_b = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset rsp/ready/busy", {20'd0, r0_ready, r1_ready, rsp_valid, rsp_id, rsp_err, busy, ctrl_v()}, 32'd0);
    check("reset data/operands", {8'd0, rsp_data, alu_a, alu_b}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: r0 AND
    do_req(0, 3'b000, 8'hA8, 8'hD5, 8'h80, 1'b0, 1'b1);
    check("t1 exec ctrl", ctrl_v(), 4'b1000);
    check("t1 exec operands", {alu_a, alu_b}, 16'hA8D5);
    check("t1 busy in exec", busy, 1'b1);
    @(posedge clk); #1;
    check("t1 rsp_valid after exec", rsp_valid, 1'b1);
    check("t1 ctrl cleared", ctrl_v(), 4'b0000);
    @(posedge clk); #1;
    check("t1 idle after 1-cycle rsp", {rsp_valid, busy}, 2'b00);

    // 2: r1 OR / NAND / NOR
    do_req(1, 3'b001, 8'hA8, 8'hD5, 8'hFD, 1'b0, 1'b1);
    do_req(1, 3'b010, 8'hA8, 8'hD5, 8'h7F, 1'b0, 1'b1);
    check("t2 nand ctrl", ctrl_v(), 4'b1001);
    do_req(1, 3'b011, 8'hA8, 8'hD5, 8'h02, 1'b0, 1'b1);

    // 3: contention, grants must alternate
    repeat (3) @(negedge clk);
    glog.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) do_req(0, r0_o[i], 8'hA8, 8'hD5, r0_d[i], 1'b0, 1'b1);
      end
      begin
        for (int j = 0; j < 4; j++) do_req(1, r1_o[j], r1_xa[j], r1_xb[j], r1_d[j], 1'b0, 1'b1);
      end
    join
    check("t3 grant count", glog.size(), 8);
    for (int k = 0; k < glog.size(); k++) check("t3 grant order", glog[k], k % 2);

    // 4: ZERO, ONES, reserved
    do_req(0, 3'b100, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1);
    do_req(0, 3'b101, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b1);
    check("t4 ones ctrl", ctrl_v(), 4'b0011);
    do_req(0, 3'b111, 8'hA8, 8'hD5, 8'h00, 1'b1, 1'b1);
    check("t4 reserved ctrl", ctrl_v(), 4'b0000);
    repeat (4) @(negedge clk);

    // 5: response backpressure with a pending requester
    @(posedge clk); #1 rsp_ready = 1'b0;
    do_req(0, 3'b011, 8'h0F, 8'h30, 8'hC0, 1'b0, 1'b1);
    @(negedge clk);
    r1_valid = 1'b1; r1_op = 3'b000; r1_a = 8'hFF; r1_b = 8'hFF;
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t5 rsp stable", {rsp_valid, rsp_id, rsp_err, rsp_data}, {3'b100, 8'hC0});
      check("t5 readys low", {r0_ready, r1_ready}, 2'b00);
    end
    r1_valid = 1'b0;
    @(posedge clk); #1 rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("t5 no txn after drop", {rsp_valid, busy}, 2'b00);

    // 6: reset during EXEC
    do_req(0, 3'b000, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("t6 async reset outs", {22'd0, rsp_valid, busy, ctrl_v(), rsp_id, rsp_err, r0_ready, r1_ready}, 32'd0);
    check("t6 async reset data", {8'd0, rsp_data, alu_a, alu_b}, 32'd0);
    r0_valid = 1'b1; r0_op = 3'b000; r0_a = 8'hF0; r0_b = 8'h3C;
    r1_valid = 1'b1; r1_op = 3'b001; r1_a = 8'hF0; r1_b = 8'h3C;
    @(negedge clk);
    check("t6 readys in reset", {r0_ready, r1_ready}, 2'b00);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    check("t6 r0 wins after reset", {r0_ready, r1_ready}, 2'b10);
    sb.push_back({1'b0, 1'b0, 8'h30});
    @(posedge clk); #1;
    r0_valid = 1'b0; r1_valid = 1'b0;

    // Drain
    for (int w = 0; w < 50 && sb.size() != 0; w++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("scoreboard drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
